ucsbece154b_dual_issue_queue: RTL and testbench

- Instruction buffer between the I-fetch stage and the dual-issue decode/hazard controller.
- Fetch pushes up to two in-order instructions (with PCs) per cycle.
- Decode sees the two oldest entries as slot 1 and slot 2. Decode reports whether it consumed 0, 1 or 2 entries, so a slot-2 instruction that was not issued (RAW/WAR/WAW hold) is re-presented as next cycle's slot 1.
- The whole queue is flushed on branch/jump mispredict.

---
 rtl/ucsbece154b_dual_issue_queue.sv | 117 +++++++++++
 tb/tb_ucsbece154b_dual_issue_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_dual_issue_queue.sv
// Dual-issue instruction queue between I-fetch and decode.
// Accepts up to two in-order instructions per cycle and presents the two oldest entries to decode.
module ucsbece154b_dual_issue_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          FetchValid0_i,
  input  logic          FetchValid1_i,
  input  logic [31:0]   FetchInstr0_i,
  input  logic [31:0]   FetchPC0_i,
  input  logic [31:0]   FetchInstr1_i,
  input  logic [31:0]   FetchPC1_i,
  output logic          FetchReady_o,
  output logic [31:0]   InstrD1_o,
  output logic [31:0]   PCD1_o,
  output logic          ValidD1_o,
  output logic [31:0]   InstrD2_o,
  output logic [31:0]   PCD2_o,
  output logic          ValidD2_o,
  input  logic          StallD_i,
  input  logic          Issue2_i,
  input  logic          Flush_i,
  output logic [AW:0]   Count_o
);

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] TWO_C   = (AW+1)'(2);

  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  logic          w_valid1;
  logic          w_valid2;
  logic          w_ready;
  logic [1:0]    w_pop;
  logic [1:0]    w_push;

  assign w_head1  = r_head + AW'(1);
  assign w_tail1  = r_tail + AW'(1);
  assign w_valid1 = (r_count != '0);
  assign w_valid2 = (r_count >= TWO_C);
  // Ready looks only at registered occupancy so decode never feeds back into fetch combinationally.
  assign w_ready  = ((DEPTH_C - r_count) >= TWO_C);

  always_comb begin
    w_pop = 2'd0;
    if (!StallD_i && w_valid1) begin
      w_pop = (Issue2_i && w_valid2) ? 2'd2 : 2'd1;
    end
  end

  always_comb begin
    w_push = 2'd0;
    if (w_ready && FetchValid0_i) begin
      w_push = FetchValid1_i ? 2'd2 : 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (Flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop);
      r_tail  <= r_tail + AW'(w_push);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Entry storage needs no reset: validity comes from r_count alone.
  always_ff @(posedge clk) begin
    if (!Flush_i) begin
      if (w_push != 2'd0) begin
        r_instr[r_tail] <= FetchInstr0_i;
        r_pc[r_tail]    <= FetchPC0_i;
      end
      if (w_push == 2'd2) begin
        r_instr[w_tail1] <= FetchInstr1_i;
        r_pc[w_tail1]    <= FetchPC1_i;
      end
    end
  end

  always_comb begin
    InstrD1_o = NOP;
    PCD1_o    = '0;
    InstrD2_o = NOP;
    PCD2_o    = '0;
    if (w_valid1) begin
      InstrD1_o = r_instr[r_head];
      PCD1_o    = r_pc[r_head];
    end
    if (w_valid2) begin
      InstrD2_o = r_instr[w_head1];
      PCD2_o    = r_pc[w_head1];
    end
  end

  assign ValidD1_o    = w_valid1;
  assign ValidD2_o    = w_valid2;
  assign FetchReady_o = w_ready;
  assign Count_o      = r_count;

endmodule

// File: tb/tb_ucsbece154b_dual_issue_queue.sv
// Directed self-checking bench for the dual-issue instruction queue.
// Inputs change 1ns after the rising edge; outputs are sampled there as well.
module tb_ucsbece154b_dual_issue_queue;

  logic        clk;
  logic        reset;
  logic        FetchValid0_i, FetchValid1_i;
  logic [31:0] FetchInstr0_i, FetchPC0_i, FetchInstr1_i, FetchPC1_i;
  logic        FetchReady_o;
  logic [31:0] InstrD1_o, PCD1_o, InstrD2_o, PCD2_o;
  logic        ValidD1_o, ValidD2_o;
  logic        StallD_i, Issue2_i, Flush_i;
  logic [3:0]  Count_o;

  int checks;
  int errors;

  ucsbece154b_dual_issue_queue #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .FetchValid0_i(FetchValid0_i), .FetchValid1_i(FetchValid1_i),
    .FetchInstr0_i(FetchInstr0_i), .FetchPC0_i(FetchPC0_i),
    .FetchInstr1_i(FetchInstr1_i), .FetchPC1_i(FetchPC1_i),
    .FetchReady_o(FetchReady_o),
    .InstrD1_o(InstrD1_o), .PCD1_o(PCD1_o), .ValidD1_o(ValidD1_o),
    .InstrD2_o(InstrD2_o), .PCD2_o(PCD2_o), .ValidD2_o(ValidD2_o),
    .StallD_i(StallD_i), .Issue2_i(Issue2_i), .Flush_i(Flush_i),
    .Count_o(Count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h00500093 + pc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n = number of instructions offered (0, 1 or 2)
  task automatic drive(input int n, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic stall, input logic iss2, input logic flush);
    FetchValid0_i = (n >= 1);
    FetchValid1_i = (n >= 2);
    FetchPC0_i    = pc0;
    FetchInstr0_i = instr_of(pc0);
    FetchPC1_i    = pc1;
    FetchInstr1_i = instr_of(pc1);
    StallD_i      = stall;
    Issue2_i      = iss2;
    Flush_i       = flush;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_count", 32'(Count_o), 0);
    chk("rst_v1", 32'(ValidD1_o), 0);
    chk("rst_v2", 32'(ValidD2_o), 0);
    chk("rst_instr1", InstrD1_o, 32'h00000013);
    chk("rst_pc1", PCD1_o, 0);
    chk("rst_ready", 32'(FetchReady_o), 1);
    reset = 1'b0;

    // Fill under stall, then exercise the count=7 boundary
    drive(2, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);  step();
    drive(2, 32'h8, 32'hC, 1'b1, 1'b0, 1'b0);  step();
    drive(2, 32'h10, 32'h14, 1'b1, 1'b0, 1'b0); step();
    chk("fill_count6", 32'(Count_o), 6);
    chk("fill_ready6", 32'(FetchReady_o), 1);
    chk("fill_pc1", PCD1_o, 32'h0);
    chk("fill_pc2", PCD2_o, 32'h4);
    chk("fill_instr1", InstrD1_o, 32'h00500093);
    drive(1, 32'h18, 32'h0, 1'b1, 1'b0, 1'b0); step();
    chk("fill_count7", 32'(Count_o), 7);
    chk("fill_ready7", 32'(FetchReady_o), 0);
    drive(2, 32'h1C, 32'h20, 1'b1, 1'b0, 1'b0); step();
    chk("full_reject", 32'(Count_o), 7);
    drive(2, 32'h1C, 32'h20, 1'b0, 1'b0, 1'b0); step();
    chk("c7_pop_nopush", 32'(Count_o), 6);
    chk("c7_pop_pc1", PCD1_o, 32'h4);
    chk("c7_pop_pc2", PCD2_o, 32'h8);
    drive(2, 32'h1C, 32'h20, 1'b1, 1'b0, 1'b0); step();
    chk("fill_count8", 32'(Count_o), 8);
    chk("fill_ready8", 32'(FetchReady_o), 0);
    chk("full_pc1", PCD1_o, 32'h4);
    drive(0, 0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc1", PCD1_o, 32'h4 + 32'(8 * i));
      chk("drain_pc2", PCD2_o, 32'h8 + 32'(8 * i));
      step();
    end
    chk("drain_count", 32'(Count_o), 0);
    chk("drain_v1", 32'(ValidD1_o), 0);

    // Slot 2 held back becomes slot 1
    drive(2, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0); step();
    drive(1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0); step();
    chk("hold_count3", 32'(Count_o), 3);
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0); step();
    chk("hold_pc1", PCD1_o, 32'h4);
    chk("hold_pc2", PCD2_o, 32'h8);
    chk("hold_count", 32'(Count_o), 2);
    drive(0, 0, 0, 1'b0, 1'b1, 1'b0); step();
    chk("dual_count", 32'(Count_o), 0);
    chk("dual_v1", 32'(ValidD1_o), 0);
    chk("dual_v2", 32'(ValidD2_o), 0);
    chk("dual_nop", InstrD1_o, 32'h00000013);
    chk("dual_pc0", PCD1_o, 0);

    // Streaming across pointer wrap-around
    for (int i = 0; i < 10; i++) begin
      drive(2, 32'h100 + 32'(8 * i), 32'h104 + 32'(8 * i), 1'b0, 1'b1, 1'b0);
      step();
      chk("strm_v2", 32'(ValidD2_o), 1);
      chk("strm_pc1", PCD1_o, 32'h100 + 32'(8 * i));
      chk("strm_pc2", PCD2_o, 32'h104 + 32'(8 * i));
      chk("strm_instr2", InstrD2_o, instr_of(32'h104 + 32'(8 * i)));
    end
    drive(0, 0, 0, 1'b0, 1'b1, 1'b0); step();
    chk("strm_count", 32'(Count_o), 0);

    // Flush wins over a same-cycle push
    drive(2, 32'h200, 32'h204, 1'b1, 1'b0, 1'b0); step();
    drive(2, 32'h208, 32'h20C, 1'b1, 1'b0, 1'b0); step();
    drive(1, 32'h210, 32'h0, 1'b1, 1'b0, 1'b0);   step();
    chk("pre_flush_count", 32'(Count_o), 5);
    drive(2, 32'h300, 32'h304, 1'b1, 1'b0, 1'b1); step();
    chk("flush_count", 32'(Count_o), 0);
    chk("flush_v1", 32'(ValidD1_o), 0);
    chk("flush_v2", 32'(ValidD2_o), 0);
    drive(1, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0); step();
    chk("post_flush_pc1", PCD1_o, 32'h40);
    chk("post_flush_v2", 32'(ValidD2_o), 0);
    chk("post_flush_count", 32'(Count_o), 1);

    // Issue2 with a single entry pops one; an empty queue pops none
    drive(0, 0, 0, 1'b0, 1'b1, 1'b0); step();
    chk("single_pop_count", 32'(Count_o), 0);
    chk("single_pop_v1", 32'(ValidD1_o), 0);
    step();
    chk("empty_no_underflow", 32'(Count_o), 0);

    // Asynchronous reset between edges
    drive(2, 32'h500, 32'h504, 1'b1, 1'b0, 1'b0); step();
    drive(2, 32'h508, 32'h50C, 1'b1, 1'b0, 1'b0); step();
    chk("pre_areset_count", 32'(Count_o), 4);
    drive(0, 0, 0, 1'b1, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_count", 32'(Count_o), 0);
    chk("areset_v1", 32'(ValidD1_o), 0);
    chk("areset_pc1", PCD1_o, 0);
    step();
    reset = 1'b0;
    step();
    chk("after_areset_count", 32'(Count_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
